// File: rtl/replica_order_xfer.sv
// Per-replica city-ordering store with neighbour transfer engine.
// exchange_ex encoding: 0 NOP, 1 SELF, 2 PREV, 3 FOLW. Optional macro: ORDER_CHECKSUM_EN.
module replica_order_xfer #(
    parameter int id          = 0,
    parameter int replica_num = 32,
    parameter int city_num    = 30,
    parameter int city_w      = 8,
    parameter int dist_w      = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        exchange_ex,
    input  logic [city_w-1:0] prev_city,
    input  logic              prev_valid,
    input  logic [city_w-1:0] folw_city,
    input  logic              folw_valid,
    input  logic [dist_w-1:0] prev_dist,
    input  logic [dist_w-1:0] folw_dist,
    output logic [city_w-1:0] out_city,
    output logic              out_valid,
    output logic [dist_w-1:0] out_dist,
    output logic              busy,
    output logic              err,
    input  logic [city_w-1:0] rd_addr,
    output logic [city_w-1:0] rd_data,
    input  logic              wr_en,
    input  logic [city_w-1:0] wr_addr,
    input  logic [city_w-1:0] wr_data,
    input  logic              dist_wr,
    input  logic [dist_w-1:0] dist_in
);

    localparam logic [1:0] CMD_NOP  = 2'd0;
    localparam logic [1:0] CMD_PREV = 2'd2;
    localparam logic [1:0] CMD_FOLW = 2'd3;
    localparam logic [city_w-1:0] LAST = city_w'(city_num - 1);

    if (city_num < 2 || city_num > 256 || (2 ** city_w) < city_num ||
        id < 0 || replica_num < 1 || id >= replica_num) begin : g_bad_cfg
        $error("replica_order_xfer: illegal parameter combination");
    end

    typedef enum logic [1:0] {INIT, IDLE, XFER} state_t;

    state_t            state, next_state;
    logic [city_w-1:0] k;
    logic [1:0]        sel;
    logic [dist_w-1:0] dist_hold;
    logic [city_w-1:0] ram [2**city_w];

    logic              last, take, nb_valid;
    logic [city_w-1:0] nb_city;
    logic              start, stream_rd, err_set, ram_we;
    logic [city_w-1:0] stream_addr, ram_waddr, ram_wdata;

    assign last     = (k == LAST);
    assign take     = (sel == CMD_PREV) || (sel == CMD_FOLW);
    assign nb_valid = (sel == CMD_PREV) ? prev_valid : folw_valid;
    assign nb_city  = (sel == CMD_PREV) ? prev_city  : folw_city;
    assign busy     = (state != IDLE);

`ifdef ORDER_CHECKSUM_EN
    localparam int SUM_W = city_w + 8;
    localparam logic [SUM_W-1:0] SUM_EXP = SUM_W'(city_num * (city_num - 1) / 2);

    logic [SUM_W-1:0] sum, sum_next;

    // A received permutation of 0..city_num-1 must add up to the triangular number.
    always_comb begin
        sum_next = (k == '0) ? '0 : sum;
        if (take && nb_valid) begin
            sum_next = sum_next + SUM_W'(nb_city);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= '0;
        end else if (state == XFER) begin
            sum <= sum_next;
        end
    end
`endif

    always_comb begin
        next_state  = state;
        start       = 1'b0;
        stream_rd   = 1'b0;
        stream_addr = '0;
        err_set     = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = wr_addr;
        ram_wdata   = wr_data;
        case (state)
            INIT: begin
                ram_we    = 1'b1;
                ram_waddr = k;
                ram_wdata = k;
                if (last) next_state = IDLE;
                if (exchange_ex != CMD_NOP) err_set = 1'b1;
            end
            IDLE: begin
                ram_we = wr_en;
                if (exchange_ex != CMD_NOP) begin
                    next_state = XFER;
                    start      = 1'b1;
                    stream_rd  = 1'b1;
                end
            end
            XFER: begin
                // Beat k is written while beat k+1 is read, so the addresses never collide.
                stream_rd   = !last;
                stream_addr = k + city_w'(1);
                if (last) next_state = IDLE;
                if (wr_en || dist_wr || exchange_ex != CMD_NOP) err_set = 1'b1;
                if (take) begin
                    if (nb_valid) begin
                        ram_we    = 1'b1;
                        ram_waddr = k;
                        ram_wdata = nb_city;
                    end else begin
                        err_set = 1'b1;
                    end
                end
`ifdef ORDER_CHECKSUM_EN
                if (take && last && sum_next != SUM_EXP) err_set = 1'b1;
`endif
            end
            default: next_state = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= INIT;
            k         <= '0;
            sel       <= CMD_NOP;
            dist_hold <= '0;
            out_city  <= '0;
            out_valid <= 1'b0;
            out_dist  <= '0;
            err       <= 1'b0;
            rd_data   <= '0;
        end else begin
            state     <= next_state;
            k         <= (state == IDLE || last) ? '0 : k + city_w'(1);
            rd_data   <= ram[rd_addr];
            out_valid <= stream_rd;
            if (err_set) err <= 1'b1;
            if (start) sel <= exchange_ex;
            if (stream_rd) out_city <= ram[stream_addr];
            if (state == IDLE && dist_wr) out_dist <= dist_in;
            // The neighbour's distance only moves on its own last beat, so beat 0 is a safe sample point.
            if (state == XFER) begin
                if (k == '0) dist_hold <= (sel == CMD_PREV) ? prev_dist : folw_dist;
                if (last && take) out_dist <= dist_hold;
            end
        end
    end

endmodule

// File: tb/tb_replica_order_xfer.sv
// Directed bench for replica_order_xfer with city_num=30: init, local access, SELF/PREV/FOLW transfers and error cases.
module tb_replica_order_xfer;

    localparam int CITY_NUM = 30;
    localparam int CW = 8;
    localparam int DW = 24;
    localparam logic [1:0] NOP = 2'd0, SELF = 2'd1, PREV = 2'd2, FOLW = 2'd3;

    logic          clk;
    logic          reset;
    logic [1:0]    exchange_ex;
    logic [CW-1:0] prev_city, folw_city, out_city, rd_addr, rd_data, wr_addr, wr_data;
    logic          prev_valid, folw_valid, out_valid, busy, err, wr_en, dist_wr;
    logic [DW-1:0] prev_dist, folw_dist, out_dist, dist_in;

    int            errors = 0;
    int            checks = 0;
    logic [CW-1:0] model [CITY_NUM];
    logic [CW-1:0] val;

    replica_order_xfer #(.id(0), .replica_num(32), .city_num(CITY_NUM), .city_w(CW), .dist_w(DW)) dut (
        .clk(clk), .reset(reset), .exchange_ex(exchange_ex),
        .prev_city(prev_city), .prev_valid(prev_valid), .folw_city(folw_city), .folw_valid(folw_valid),
        .prev_dist(prev_dist), .folw_dist(folw_dist),
        .out_city(out_city), .out_valid(out_valid), .out_dist(out_dist), .busy(busy), .err(err),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dist_wr(dist_wr), .dist_in(dist_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        exchange_ex = NOP;
        prev_city = '0; prev_valid = 1'b0; folw_city = '0; folw_valid = 1'b0;
        prev_dist = '0; folw_dist = '0;
        rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        dist_wr = 1'b0; dist_in = '0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_idle_timeout: busy=%b expected 0", name, busy);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_idle("reset");
        for (int i = 0; i < CITY_NUM; i++) model[i] = CW'(i);
    endtask

    task automatic test_reset();
        int cnt = 0;
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if ({out_city, out_valid, out_dist, busy, err, rd_data} !== {8'd0, 1'b0, 24'd0, 1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("[TB] FAIL reset_values: city=%0d valid=%b dist=%0d busy=%b err=%b rd=%0d expected 0/0/0/1/0/0",
                     out_city, out_valid, out_dist, busy, err, rd_data);
        end
        reset = 1'b1;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 30) begin
            errors++;
            $display("[TB] FAIL init_busy_cycles: got %0d expected 30", cnt);
        end
        for (int i = 0; i < CITY_NUM; i++) model[i] = CW'(i);
        rd_addr = 8'd7;
        @(negedge clk);
        checks++;
        if (rd_data !== 8'd7) begin
            errors++;
            $display("[TB] FAIL init_read7: got %0d expected 7", rd_data);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL init_err: got %b expected 0", err);
        end
    endtask

    task automatic test_self();
        wr_en = 1'b1; wr_addr = 8'd3; wr_data = 8'd12;
        dist_wr = 1'b1; dist_in = 24'd555;
        model[3] = 8'd12;
        @(negedge clk);
        wr_en = 1'b0; dist_wr = 1'b0;
        exchange_ex = SELF;
        @(negedge clk);
        exchange_ex = NOP;
        for (int b = 0; b < CITY_NUM; b++) begin
            checks++;
            if ({busy, out_valid, out_city} !== {1'b1, 1'b1, model[b]}) begin
                errors++;
                $display("[TB] FAIL self_beat%0d: busy=%b valid=%b city=%0d expected 1/1/%0d", b, busy, out_valid, out_city, model[b]);
            end
            @(negedge clk);
        end
        checks++;
        if ({busy, out_valid, out_dist} !== {1'b0, 1'b0, 24'd555}) begin
            errors++;
            $display("[TB] FAIL self_end: busy=%b valid=%b dist=%0d expected 0/0/555", busy, out_valid, out_dist);
        end
        rd_addr = '0;
        for (int a = 0; a < CITY_NUM; a++) begin
            @(negedge clk);
            checks++;
            if (rd_data !== model[a]) begin
                errors++;
                $display("[TB] FAIL self_ram%0d: got %0d expected %0d", a, rd_data, model[a]);
            end
            rd_addr = CW'(a + 1);
        end
    endtask

    task automatic test_prev();
        prev_dist = 24'd1000;
        exchange_ex = PREV;
        @(negedge clk);
        exchange_ex = NOP;
        for (int b = 0; b < CITY_NUM; b++) begin
            checks++;
            if ({out_valid, out_city} !== {1'b1, model[b]}) begin
                errors++;
                $display("[TB] FAIL prev_beat%0d: valid=%b city=%0d expected 1/%0d", b, out_valid, out_city, model[b]);
            end
            prev_city = CW'(29 - b);
            prev_valid = 1'b1;
            model[b] = CW'(29 - b);
            @(negedge clk);
        end
        prev_valid = 1'b0;
        checks++;
        if ({busy, err, out_dist} !== {1'b0, 1'b0, 24'd1000}) begin
            errors++;
            $display("[TB] FAIL prev_end: busy=%b err=%b dist=%0d expected 0/0/1000", busy, err, out_dist);
        end
        rd_addr = '0;
        for (int a = 0; a < CITY_NUM; a++) begin
            @(negedge clk);
            checks++;
            if (rd_data !== model[a]) begin
                errors++;
                $display("[TB] FAIL prev_ram%0d: got %0d expected %0d", a, rd_data, model[a]);
            end
            rd_addr = CW'(a + 1);
        end
    endtask

    task automatic test_checksum();
        logic exp_err;
`ifdef ORDER_CHECKSUM_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        prev_dist = 24'd2000;
        exchange_ex = PREV;
        @(negedge clk);
        exchange_ex = NOP;
        for (int b = 0; b < CITY_NUM; b++) begin
            val = (b == 24) ? 8'd4 : CW'(29 - b);
            prev_city = val;
            prev_valid = 1'b1;
            model[b] = val;
            if (b == 29) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL cksum_pre_last_err: got %b expected 0", err);
                end
            end
            @(negedge clk);
        end
        prev_valid = 1'b0;
        checks++;
        if ({err, out_dist} !== {exp_err, 24'd2000}) begin
            errors++;
            $display("[TB] FAIL cksum_end: err=%b dist=%0d expected %b/2000", err, out_dist, exp_err);
        end
    endtask

    task automatic test_folw_drop();
        do_reset();
        folw_dist = 24'd77;
        exchange_ex = FOLW;
        @(negedge clk);
        exchange_ex = NOP;
        for (int b = 0; b < CITY_NUM; b++) begin
            checks++;
            if ({out_valid, out_city} !== {1'b1, model[b]}) begin
                errors++;
                $display("[TB] FAIL folw_beat%0d: valid=%b city=%0d expected 1/%0d", b, out_valid, out_city, model[b]);
            end
            if (b == 5 || b == 6) begin
                checks++;
                if (err !== (b == 6)) begin
                    errors++;
                    $display("[TB] FAIL folw_err_beat%0d: got %b expected %b", b, err, b == 6);
                end
            end
            val = CW'((b + 10) % CITY_NUM);
            folw_city = val;
            folw_valid = (b != 5);
            if (b != 5) model[b] = val;
            @(negedge clk);
        end
        folw_valid = 1'b0;
        checks++;
        if ({busy, err, out_dist} !== {1'b0, 1'b1, 24'd77}) begin
            errors++;
            $display("[TB] FAIL folw_end: busy=%b err=%b dist=%0d expected 0/1/77", busy, err, out_dist);
        end
        rd_addr = '0;
        for (int a = 0; a < CITY_NUM; a++) begin
            @(negedge clk);
            checks++;
            if (rd_data !== model[a]) begin
                errors++;
                $display("[TB] FAIL folw_ram%0d: got %0d expected %0d", a, rd_data, model[a]);
            end
            rd_addr = CW'(a + 1);
        end
    endtask

    task automatic test_mid_xfer();
        do_reset();
        exchange_ex = SELF;
        @(negedge clk);
        exchange_ex = NOP;
        for (int b = 0; b < CITY_NUM; b++) begin
            checks++;
            if ({busy, out_valid, out_city} !== {1'b1, 1'b1, model[b]}) begin
                errors++;
                $display("[TB] FAIL mid_beat%0d: busy=%b valid=%b city=%0d expected 1/1/%0d", b, busy, out_valid, out_city, model[b]);
            end
            if (b == 9) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL mid_err_before: got %b expected 0", err);
                end
                wr_en = 1'b1; wr_addr = 8'd20; wr_data = 8'd99;
                dist_wr = 1'b1; dist_in = 24'd4444;
                exchange_ex = PREV;
            end
            if (b == 10) begin
                wr_en = 1'b0; dist_wr = 1'b0; exchange_ex = NOP;
                checks++;
                if (err !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL mid_err_after: got %b expected 1", err);
                end
            end
            @(negedge clk);
        end
        checks++;
        if ({busy, out_valid, out_dist} !== {1'b0, 1'b0, 24'd0}) begin
            errors++;
            $display("[TB] FAIL mid_end: busy=%b valid=%b dist=%0d expected 0/0/0", busy, out_valid, out_dist);
        end
        rd_addr = 8'd20;
        @(negedge clk);
        checks++;
        if ({out_valid, rd_data} !== {1'b0, 8'd20}) begin
            errors++;
            $display("[TB] FAIL mid_after: valid=%b ram20=%0d expected 0/20", out_valid, rd_data);
        end
    endtask

    task automatic test_reset_mid_xfer();
        wr_en = 1'b1; wr_addr = 8'd4; wr_data = 8'd17;
        @(negedge clk);
        wr_en = 1'b0;
        exchange_ex = SELF;
        @(negedge clk);
        exchange_ex = NOP;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, out_valid} !== {1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL rstmid_state: busy=%b valid=%b expected 1/0", busy, out_valid);
        end
        reset = 1'b1;
        wait_idle("rstmid");
        rd_addr = 8'd4;
        @(negedge clk);
        checks++;
        if (rd_data !== 8'd4) begin
            errors++;
            $display("[TB] FAIL rstmid_ram4: got %0d expected 4", rd_data);
        end
    endtask

    initial begin
        $display("[TB] replica_order_xfer bench start");
        test_reset();
        test_self();
        test_prev();
        test_checksum();
        test_folw_drop();
        test_mid_xfer();
        test_reset_mid_xfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/replica_order_xfer.md
Name: replica_order_xfer

Overview:
- Per-replica city-ordering store and neighbour transfer engine; sits directly downstream of the exchange-decision stage and consumes its exchange_ex command.
- On a PREV/FOLW command it overwrites its ordering and total distance with the neighbour's copy.
- It always streams its own ordering to both neighbours so that they can take it.
- Between transfers it serves single-entry read/write from the optimisation stage.

Parameters:
- id, 0, replica index; used only for the identity-init pattern offset (none, 0 retained for uniformity).
- replica_num, 32, replica count (informational).
- city_num, 30, ordering length; legal range 2..256.
- city_w, 8, bits per city index; must satisfy 2^city_w >= city_num.
- dist_w, 24, total-distance width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- exchange_ex  in  exchange_command_t  NOP/SELF/PREV/FOLW, one-cycle command.
- prev_city  in  city_w  ordering stream from previous replica.
- prev_valid  in  1  stream valid from previous replica.
- folw_city  in  city_w  ordering stream from following replica.
- folw_valid  in  1  stream valid from following replica.
- prev_dist  in  dist_w  previous replica's out_dist.
- folw_dist  in  dist_w  following replica's out_dist.
- out_city  out  city_w  own ordering stream.
- out_valid  out  1  stream beat valid.
- out_dist  out  dist_w  own total distance.
- busy  out  1  init or transfer in progress.
- err  out  1  sticky protocol error.
- rd_addr  in  city_w  local read address.
- rd_data  out  city_w  local read data, 1-cycle latency.
- wr_en  in  1  local write enable.
- wr_addr  in  city_w  local write address.
- wr_data  in  city_w  local write data.
- dist_wr  in  1  load out_dist from dist_in.
- dist_in  in  dist_w  new distance from the optimisation stage.

Behaviour:
- Reset values: out_city=0, out_valid=0, out_dist=0, busy=1 (INIT), err=0, rd_data=0.
- The RAM has no reset.
- FSM states: INIT, IDLE, XFER.
- INIT: counter k=0..city_num-1 writes RAM[k]=k, one entry per cycle. After city_num cycles go to IDLE and busy=0.
- Commands are ignored in INIT; a non-NOP command in INIT sets err.
- IDLE: wr_en writes RAM at the clock edge; dist_wr loads out_dist. rd_data = RAM[rd_addr] registered.
- IDLE, non-NOP command sampled at cycle T: enter XFER and latch sel=cmd. Command at T means the first XFER cycle is T+1.
- XFER beats: cycles T+1..T+city_num, out_valid=1 and out_city=RAM[k] for beat k. The RAM read for beat k is issued in cycle T+k.
- busy=1 in cycles T+1..T+city_num; return to IDLE after beat city_num-1.
- sel=PREV: at the end of cycle T+1+k, RAM[k] <= prev_city (prev_valid must be 1).
- sel=FOLW: same with folw_city/folw_valid.
- The write of k and the read of k+1 in the same cycle hit different addresses, so there is no conflict. The in-place overwrite is safe because every replica streams in lockstep.
- sel=SELF: stream only, no writes.
- out_dist updates on the last beat: PREV -> prev_dist, FOLW -> folw_dist, SELF unchanged. The neighbour's out_dist is stable through XFER because it only changes on its own last beat; sample it at beat 0 into a holding register.
- Selected neighbour valid=0 on any beat: set err, skip that write, continue counting.
- During XFER: wr_en and dist_wr are ignored and set err; a non-NOP command is ignored and sets err.
- rd_data during XFER/INIT is undefined.
- err clears only on reset.
- Reset asserted mid-XFER: state returns to INIT immediately and the ordering is reinitialised to identity.

Optional Feature:
- Macro: ORDER_CHECKSUM_EN.
- When defined: during PREV/FOLW XFER, accumulate the sum of received city values (width city_w+8). At the last beat compare it with city_num*(city_num-1)/2; a mismatch sets err, since the received stream is not a permutation.
- When undefined: no accumulator; err covers protocol errors only.

Test Plan:
- Reset release, city_num=30 -> busy high 30 cycles; afterwards rd_addr=7 gives rd_data=7 next cycle; err=0.
- IDLE, wr_en addr 3 data 12, then SELF command at T -> out_valid T+1..T+30, out_city beat 3 = 12, RAM unchanged, out_dist unchanged.
- PREV command with prev stream 29..0 and prev_valid=1, prev_dist=1000 -> afterwards RAM[k]=29-k, out_dist=1000, own stream emitted the old ordering.
- FOLW command with folw_valid dropped on beat 5 -> err=1; RAM[5] retains its old value; the other beats are written.
- Command or wr_en issued at T+10 of an XFER -> ignored, err=1, transfer completes at T+30.
- ORDER_CHECKSUM_EN: PREV stream with city 4 duplicated (replacing 5) -> err=1 at the last beat. Without the macro -> err=0.
